// File: rtl/leaf_merge_pkg.sv
`default_nettype none
// ============================================================================
// Module : leaf_merge_pkg
// Brief  : Shared FSM type and pointer helper for the leaf stream merger.
// Rev    : 1.0
// ============================================================================
package leaf_merge_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } merge_state_t;

    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/leaf_rr_pick.sv
`default_nettype none
// ============================================================================
// Module : leaf_rr_pick
// Brief  : Combinational search for the first requester at or after ptr.
// Rev    : 1.0
// ============================================================================
module leaf_rr_pick #(
    parameter int NUM_IN = 5,
    parameter int ID_W   = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [ID_W-1:0]   ptr,
    output logic              gnt_valid,
    output logic [ID_W-1:0]   gnt_idx
);

    int unsigned     cand;
    logic [ID_W-1:0] cand_idx;

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand      = 32'd0;
        cand_idx  = '0;
        // Walk from the farthest candidate back to ptr so the nearest requester wins.
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            cand = 32'(ptr) + 32'(k);
            if (cand >= 32'(NUM_IN)) begin
                cand = cand - 32'(NUM_IN);
            end
            cand_idx = ID_W'(cand);
            if (req[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/leaf_stream_merger.sv
`default_nettype none
// ============================================================================
// Module : leaf_stream_merger
// Brief  : Packet-granular round-robin merge of NUM_IN streams with truncation.
// Rev    : 1.0
// ============================================================================
module leaf_stream_merger
    import leaf_merge_pkg::*;
#(
    parameter int  NUM_IN    = 5,
    parameter int  DATA_W    = 32,
    parameter int  MAX_BEATS = 16,
    localparam int ID_W      = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_last,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic                     err_trunc
);

    localparam int               CNT_W   = $clog2(MAX_BEATS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    merge_state_t      state;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   lock;
    logic [CNT_W-1:0]  cnt;

    logic [ID_W-1:0]   pick_idx;
    logic              pick_valid;
    logic [ID_W-1:0]   sel;
    logic              sel_valid;
    logic              load_en;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic [CNT_W-1:0]  cnt_next;
    logic              at_max;
    logic              beat_last;

    leaf_rr_pick #(
        .NUM_IN (NUM_IN),
        .ID_W   (ID_W)
    ) u_pick (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    assign load_en   = !out_valid || out_ready;
    assign sel       = (state == LOCKED) ? lock : pick_idx;
    assign sel_valid = (state == LOCKED) || pick_valid;

    generate
        for (genvar i = 0; i < NUM_IN; i++) begin : g_ready
            assign in_ready[i] = rst_n && load_en && sel_valid && (sel == ID_W'(i));
        end
    endgenerate

    assign xfer      = |(in_valid & in_ready);
    assign sel_data  = in_data[sel*DATA_W +: DATA_W];
    assign sel_last  = in_last[sel];
    assign cnt_next  = (state == IDLE) ? CNT_W'(1) : cnt + 1'b1;
    assign at_max    = (cnt_next == MAX_CNT);
    // Hitting the beat limit closes the packet whether or not the source marked it.
    assign beat_last = sel_last || at_max;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            lock      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
            err_trunc <= 1'b0;
        end else begin
            if (load_en) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= sel_data;
                    out_id   <= sel;
                    out_last <= beat_last;
                end
            end
            if (xfer) begin
                if (beat_last) begin
                    state <= IDLE;
                    ptr   <= ID_W'(rr_next(32'(sel), NUM_IN));
                    cnt   <= '0;
                end else begin
                    state <= LOCKED;
                    lock  <= sel;
                    cnt   <= cnt_next;
                end
                if (at_max && !sel_last) begin
                    err_trunc <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_leaf_stream_merger.sv
`default_nettype none
// tb_leaf_stream_merger: per-source expected queues, a reference arbiter on the input
// side and an output monitor that pops and compares every delivered beat.
module tb_leaf_stream_merger;

    localparam int NUM_IN    = 5;
    localparam int DATA_W    = 32;
    localparam int MAX_BEATS = 16;
    localparam int ID_W      = $clog2(NUM_IN);

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } src_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
        logic              trunc;
    } beat_t;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_last;
    logic [NUM_IN-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [ID_W-1:0]          out_id;
    logic                     out_last;
    logic                     out_ready;
    logic                     err_trunc;

    src_t  src_q[NUM_IN][$];
    beat_t exp_q[NUM_IN][$];
    int    seen_ids[$];
    int    want_ids[$];

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;
    bit gaps     = 1'b0;
    bit exp_err  = 1'b0;
    int open_src = -1;
    int rr_ptr   = 0;
    int pkt_cnt  = 0;

    leaf_stream_merger #(
        .NUM_IN    (NUM_IN),
        .DATA_W    (DATA_W),
        .MAX_BEATS (MAX_BEATS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_trunc (err_trunc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Expected output framing is a pure function of each source's own beat sequence.
    task automatic send_pkt(input int s, input int len, input bit has_last,
                            input logic [DATA_W-1:0] base, input bit rand_data);
        src_t  sb;
        beat_t eb;
        for (int k = 1; k <= len; k++) begin
            sb.data  = rand_data ? DATA_W'($urandom) : base + DATA_W'(k - 1);
            sb.last  = has_last && (k == len);
            eb.data  = sb.data;
            eb.trunc = ((k % MAX_BEATS) == 0) && !sb.last;
            eb.last  = sb.last || ((k % MAX_BEATS) == 0);
            src_q[s].push_back(sb);
            exp_q[s].push_back(eb);
        end
    endtask

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (src_q[i].size() != 0 || exp_q[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_drain(input int budget);
        int c = 0;
        while (c < budget && !all_empty()) begin
            @(negedge clk); #4;
            c++;
        end
        chk("drain_timeout", all_empty(), 1);
        repeat (2) begin
            @(negedge clk); #4;
        end
    endtask

    task automatic check_ids(input string name);
        chk({name, "_count"}, seen_ids.size(), want_ids.size());
        for (int i = 0; i < want_ids.size() && i < seen_ids.size(); i++) begin
            chk(name, seen_ids[i], want_ids[i]);
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_out_valid"}, out_valid, 0);
        chk({name, "_out_data"},  out_data,  0);
        chk({name, "_out_id"},    out_id,    0);
        chk({name, "_out_last"},  out_last,  0);
        chk({name, "_err_trunc"}, err_trunc, 0);
        chk({name, "_in_ready"},  in_ready,  0);
    endtask

    // Source drivers and downstream ready, updated on the falling edge.
    initial begin : drv
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
            for (int i = 0; i < NUM_IN; i++) begin
                if (src_q[i].size() > 0 && (in_valid[i] || !gaps || $urandom_range(0, 2) != 0)) begin
                    in_valid[i]                  = 1'b1;
                    in_data[i*DATA_W +: DATA_W]  = src_q[i][0].data;
                    in_last[i]                   = src_q[i][0].last;
                end else begin
                    in_valid[i] = 1'b0;
                    in_last[i]  = 1'b0;
                end
            end
        end
    end

    // Reference arbiter: who must be granted, and source-side packet tracking.
    initial begin : acc
        logic [NUM_IN-1:0] xf;
        logic [NUM_IN-1:0] mask;
        bit                le;
        int                exp_src;
        src_t              b;
        forever begin
            @(negedge clk); #4;
            if (!rst_n) begin
                chk("ready_in_reset", in_ready, 0);
                open_src = -1;
                rr_ptr   = 0;
                pkt_cnt  = 0;
            end else begin
                xf = in_valid & in_ready;
                le = !out_valid || out_ready;
                chk("ready_onehot", ($countones(in_ready) <= 1), 1);
                if (!le) begin
                    chk("ready_when_blocked", in_ready, 0);
                end else if (open_src >= 0) begin
                    mask = NUM_IN'(1) << open_src;
                    chk("ready_locked", in_ready, mask);
                end else begin
                    exp_src = -1;
                    for (int k = 0; k < NUM_IN; k++) begin
                        if (exp_src < 0 && in_valid[(rr_ptr + k) % NUM_IN]) exp_src = (rr_ptr + k) % NUM_IN;
                    end
                    mask = (exp_src < 0) ? '0 : NUM_IN'(1) << exp_src;
                    chk("ready_rr_grant", in_ready, mask);
                end
                for (int s = 0; s < NUM_IN; s++) begin
                    if (xf[s] && src_q[s].size() > 0) begin
                        b = src_q[s].pop_front();
                        pkt_cnt++;
                        if (b.last || pkt_cnt == MAX_BEATS) begin
                            open_src = -1;
                            pkt_cnt  = 0;
                            rr_ptr   = (s + 1) % NUM_IN;
                        end else begin
                            open_src = s;
                        end
                    end
                end
            end
        end
    end

    // Output monitor: scoreboard pop, stall stability, packet atomicity, sticky error.
    initial begin : mon
        beat_t             e;
        int                id;
        int                out_open;
        bit                prev_stall;
        logic [DATA_W+ID_W:0] prev_word;
        out_open   = -1;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk); #4;
            if (!rst_n) begin
                prev_stall = 1'b0;
                out_open   = -1;
                exp_err    = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_payload", {out_data, out_id, out_last}, prev_word);
                end
                if (out_valid && out_ready) begin
                    id = int'(out_id);
                    seen_ids.push_back(id);
                    chk("out_id_range", (id < NUM_IN), 1);
                    if (out_open >= 0) chk("packet_atomic", out_id, out_open);
                    out_open = out_last ? -1 : id;
                    if (id < NUM_IN) begin
                        chk("beat_expected", (exp_q[id].size() > 0), 1);
                        if (exp_q[id].size() > 0) begin
                            e = exp_q[id].pop_front();
                            chk("out_data", out_data, e.data);
                            chk("out_last", out_last, e.last);
                            if (e.trunc) exp_err = 1'b1;
                            chk("err_trunc", err_trunc, exp_err);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_word  = {out_data, out_id, out_last};
            end
        end
    end

    initial begin : main
        int c;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #4;
        check_reset_vals("reset");
        @(negedge clk); #2;
        rst_n = 1'b1;
        #2;

        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #4;
            chk("idle_in_ready", in_ready, 0);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_err", err_trunc, 0);
        end

        // Single-beat packets on 0,2,4, twice, to see the pointer wrap.
        for (int r = 0; r < 2; r++) begin
            seen_ids.delete();
            send_pkt(0, 1, 1'b1, 32'h100 + 32'(r), 1'b0);
            send_pkt(2, 1, 1'b1, 32'h200 + 32'(r), 1'b0);
            send_pkt(4, 1, 1'b1, 32'h400 + 32'(r), 1'b0);
            wait_drain(200);
            want_ids = '{0, 2, 4};
            check_ids((r == 0) ? "rr_order" : "rr_wrap");
        end

        // A three-beat packet on 1 holds off input 3.
        seen_ids.delete();
        send_pkt(1, 3, 1'b1, 32'hA, 1'b0);
        send_pkt(3, 1, 1'b1, 32'h300, 1'b0);
        wait_drain(200);
        want_ids = '{1, 1, 1, 3};
        check_ids("lock_order");

        // Downstream stall with a beat waiting on input 0.
        seen_ids.delete();
        rdy_mode = 2;
        send_pkt(0, 2, 1'b1, 32'hDEADBEEF, 1'b0);
        c = 0;
        while (!out_valid && c < 20) begin
            @(negedge clk); #4;
            c++;
        end
        for (int k = 0; k < 4; k++) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, 32'hDEADBEEF);
            chk("hold_ready0", in_ready[0], 0);
            @(negedge clk); #4;
        end
        rdy_mode = 0;
        wait_drain(200);
        want_ids = '{0, 0};
        check_ids("stall_order");

        // Over-long packet on 2: twenty unmarked beats, then a closing beat.
        seen_ids.delete();
        send_pkt(2, 21, 1'b1, 32'h2000, 1'b0);
        wait_drain(400);
        chk("err_after_trunc", err_trunc, 1);
        want_ids.delete();
        for (int k = 0; k < 21; k++) want_ids.push_back(2);
        check_ids("trunc_order");

        // Reset while locked on input 3.
        send_pkt(3, 6, 1'b1, 32'h3000, 1'b0);
        c = 0;
        while (open_src != 3 && c < 50) begin
            @(negedge clk); #4;
            c++;
        end
        chk("lock_seen", open_src, 3);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            src_q[i].delete();
            exp_q[i].delete();
        end
        repeat (2) @(negedge clk);
        #4;
        check_reset_vals("midpkt_reset");
        @(negedge clk); #2;
        rst_n = 1'b1;
        #2;
        seen_ids.delete();
        send_pkt(4, 1, 1'b1, 32'h4400, 1'b0);
        send_pkt(3, 1, 1'b1, 32'h3300, 1'b0);
        send_pkt(2, 1, 1'b1, 32'h2200, 1'b0);
        wait_drain(200);
        want_ids = '{2, 3, 4};
        check_ids("post_reset_order");

        // Random traffic with gaps and random backpressure.
        rdy_mode = 1;
        gaps     = 1'b1;
        for (int p = 0; p < 80; p++) begin
            send_pkt($urandom_range(0, NUM_IN - 1),
                     ($urandom_range(0, 4) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 6),
                     1'b1, '0, 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 8)) @(negedge clk);
                #4;
            end
        end
        wait_drain(20000);
        gaps     = 1'b0;
        rdy_mode = 0;
        repeat (3) begin
            @(negedge clk); #4;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
